// File: rtl/serialtopara.sv
// -----------------------------------------------------------------------------
// serialtopara: two-lane serial-to-parallel receiver.
//
// Each lane shifts in one bit per clk, MSB first. It hunts for the comma symbol
// to find byte alignment. After SYNC_COUNT consecutive aligned commas it locks
// (ACTIVE). From then on it delivers every non-comma byte with a one-cycle
// valid strobe. The two lanes share only clk and reset.
//
// Ports (top):
//   clk          in   bit-rate clock, rising edge
//   reset        in   synchronous, active-high reset
//   in0 / in1    in   lane serial bits, MSB of each byte first
//   out0 / out1  out  [7:0] last data byte received on the lane
//   valid_out0/1 out  one-cycle strobe: outN updated this cycle
//   active0/1    out  lane aligned and delivering data
// -----------------------------------------------------------------------------

// One receive lane: alignment FSM plus byte capture.
//   clk_i, reset_i : clock and synchronous active-high reset
//   in_i           : serial bit
//   data_o         : last data byte
//   valid_o        : one-cycle strobe for a new data byte
//   active_o       : lane locked
module serialtopara_lane #(
  parameter logic [7:0]  COMMA      = 8'hBC,
  parameter int unsigned SYNC_COUNT = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       in_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       active_o
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  sr_q, sr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  ccnt_q, ccnt_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        active_q, active_d;

  logic [7:0]  win;
  logic        boundary;
  logic        is_comma;
  logic [3:0]  ccnt_inc;

  // The window is the byte that ends with the bit arriving this cycle.
  assign win      = {sr_q[6:0], in_i};
  assign boundary = (cnt_q == 3'd7);
  assign is_comma = (win == COMMA);
  assign ccnt_inc = ccnt_q + 4'd1;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    sr_d    = win;
    cnt_d   = cnt_q + 3'd1;
    ccnt_d  = ccnt_q;
    data_d  = data_q;
    valid_d = 1'b0;

    unique case (state_q)
      HUNT: begin
        cnt_d  = 3'd0;
        ccnt_d = 4'd0;
        if (is_comma) begin
          // A comma ends here, so cnt restarts at 0 and the next boundary
          // falls 8 bits later.
          ccnt_d  = 4'd1;
          state_d = (SYNC_COUNT == 1) ? ACTIVE : SYNC;
        end
      end

      SYNC: begin
        if (boundary) begin
          if (is_comma) begin
            ccnt_d = ccnt_inc;
            if (ccnt_inc == 4'(SYNC_COUNT)) state_d = ACTIVE;
          end else begin
            // Misaligned or broken comma run: restart the hunt. This window is
            // not re-examined; the next window can match in HUNT.
            state_d = HUNT;
            ccnt_d  = 4'd0;
            cnt_d   = 3'd0;
          end
        end
      end

      ACTIVE: begin
        // A comma at a boundary is idle fill: out holds and no strobe.
        if (boundary && !is_comma) begin
          data_d  = win;
          valid_d = 1'b1;
        end
      end

      default: begin
        state_d = HUNT;
        cnt_d   = 3'd0;
        ccnt_d  = 4'd0;
      end
    endcase

    // active is registered, so it rises on the edge that completes the lock.
    active_d = (state_d == ACTIVE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of the order of the statements.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= HUNT;
      sr_q     <= 8'd0;
      cnt_q    <= 3'd0;
      ccnt_q   <= 4'd0;
      data_q   <= 8'd0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      ccnt_q   <= ccnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      active_q <= active_d;
    end
  end

  assign data_o   = data_q;
  assign valid_o  = valid_q;
  assign active_o = active_q;

endmodule

module serialtopara #(
  parameter logic [7:0]  COMMA      = 8'hBC,
  parameter int unsigned SYNC_COUNT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in0,
  input  logic       in1,
  output logic [7:0] out0,
  output logic [7:0] out1,
  output logic       valid_out0,
  output logic       valid_out1,
  output logic       active0,
  output logic       active1
);

  serialtopara_lane #(
    .COMMA      (COMMA),
    .SYNC_COUNT (SYNC_COUNT)
  ) u_lane0 (
    .clk_i    (clk),
    .reset_i  (reset),
    .in_i     (in0),
    .data_o   (out0),
    .valid_o  (valid_out0),
    .active_o (active0)
  );

  serialtopara_lane #(
    .COMMA      (COMMA),
    .SYNC_COUNT (SYNC_COUNT)
  ) u_lane1 (
    .clk_i    (clk),
    .reset_i  (reset),
    .in_i     (in1),
    .data_o   (out1),
    .valid_o  (valid_out1),
    .active_o (active1)
  );

endmodule
